// File: rtl/data_memory_responder_pkg.sv
// -----------------------------------------------------------------------------
// data_mem_pkg
// Shared types and constants for the data-memory responder.
//   state_e     : responder FSM states (IDLE, BUSY, RESP)
//   WORD_WIDTH  : data word width in bits
//   BYTE_LANES  : bytes per word
//   cnt_width() : width of the wait-state counter for a given WAIT_CYCLES
// -----------------------------------------------------------------------------
package data_mem_pkg;

    localparam int WORD_WIDTH = 32;
    localparam int BYTE_LANES = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    // $clog2(WAIT_CYCLES+1) bits hold every count value; kept at least one
    // bit wide so a zero-wait build still has a legal counter vector.
    function automatic int cnt_width(input int wait_cycles);
        int w;
        w = $clog2(wait_cycles + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/data_memory_responder_if.sv
// -----------------------------------------------------------------------------
// data_memory_responder_if
// Request/response bus between the DataPath data port and the data memory.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. The request side (req_*) is offered by the master and taken by
// the slave when req_ready is high; the response side (resp_*) is offered by
// the slave and held stable until the master raises resp_ready.
//
//   master : the core / requester
//   slave  : the memory responder
// -----------------------------------------------------------------------------
interface data_memory_responder_if;
    import data_mem_pkg::*;

    logic                  req_valid;
    logic                  req_ready;
    logic                  req_write;
    logic                  req_byte;
    logic [WORD_WIDTH-1:0] req_addr;
    logic [WORD_WIDTH-1:0] req_wdata;
    logic                  resp_valid;
    logic                  resp_ready;
    logic [WORD_WIDTH-1:0] resp_rdata;
    logic                  resp_err;

    modport master (
        output req_valid, req_write, req_byte, req_addr, req_wdata, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_write, req_byte, req_addr, req_wdata, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );

endinterface

// File: rtl/byte_lane_unit.sv
// -----------------------------------------------------------------------------
// byte_lane_unit
// Combinational byte-lane handling for the data memory (little-endian,
// lane 0 = bits [7:0]).
//   i_old_word   : current contents of the addressed word
//   i_lane       : byte lane, addr[1:0]
//   i_wdata      : store data (byte stores use bits [7:0])
//   i_byte       : 1 = byte access, 0 = word access
//   o_load_data  : load result (selected lane zero-extended for byte loads)
//   o_store_word : word to write back (lane merged into old word for bytes)
// -----------------------------------------------------------------------------
module byte_lane_unit
    import data_mem_pkg::*;
(
    input  logic [WORD_WIDTH-1:0] i_old_word,
    input  logic [1:0]            i_lane,
    input  logic [WORD_WIDTH-1:0] i_wdata,
    input  logic                  i_byte,
    output logic [WORD_WIDTH-1:0] o_load_data,
    output logic [WORD_WIDTH-1:0] o_store_word
);

    logic [7:0]            w_lane_byte;
    logic [WORD_WIDTH-1:0] w_merged;

    always_comb begin
        w_lane_byte = i_old_word[7:0];
        w_merged    = i_old_word;
        case (i_lane)
            2'd0: begin
                w_lane_byte    = i_old_word[7:0];
                w_merged[7:0]  = i_wdata[7:0];
            end
            2'd1: begin
                w_lane_byte    = i_old_word[15:8];
                w_merged[15:8] = i_wdata[7:0];
            end
            2'd2: begin
                w_lane_byte     = i_old_word[23:16];
                w_merged[23:16] = i_wdata[7:0];
            end
            default: begin
                w_lane_byte     = i_old_word[31:24];
                w_merged[31:24] = i_wdata[7:0];
            end
        endcase

        o_load_data  = i_byte ? {{(WORD_WIDTH-8){1'b0}}, w_lane_byte} : i_old_word;
        o_store_word = i_byte ? w_merged : i_wdata;
    end

endmodule

// File: rtl/data_memory_responder.sv
// -----------------------------------------------------------------------------
// data_memory_responder
// Data-memory end of the CPU data port. Accepts one load/store request at a
// time, waits WAIT_CYCLES extra cycles, then commits the access against an
// internal word-organised RAM and presents the response until it is taken.
//
// Ports
//   clk     : clock, rising edge
//   reset   : asynchronous, active-low reset
//   bus     : request/response bus (slave side), see data_memory_responder_if
//   o_state : current FSM state, for observation
//
// Parameters
//   DEPTH_WORDS : number of 32-bit words; valid byte addresses 0..DEPTH_WORDS*4-1
//   WAIT_CYCLES : extra cycles between accept and response (0 is legal)
// -----------------------------------------------------------------------------
module data_memory_responder
    import data_mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 64,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    data_memory_responder_if.slave  bus,
    output logic [1:0]              o_state
);

    localparam int                    CNT_W      = cnt_width(WAIT_CYCLES);
    localparam int                    IDX_W      = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [WORD_WIDTH-1:0] ADDR_LIMIT = WORD_WIDTH'(DEPTH_WORDS * BYTE_LANES);
    localparam logic [CNT_W-1:0]      CNT_LOAD   = CNT_W'(WAIT_CYCLES);

    localparam logic [1:0] S_IDLE = ST_IDLE;
    localparam logic [1:0] S_BUSY = ST_BUSY;
    localparam logic [1:0] S_RESP = ST_RESP;

    // FSM and counter
    logic [1:0]            r_state;
    logic [1:0]            w_state_next;
    logic [CNT_W-1:0]      r_cnt;
    logic [CNT_W-1:0]      w_cnt_next;
    logic                  r_req_ready;

    // Captured request
    logic                  r_write;
    logic                  r_byte;
    logic [WORD_WIDTH-1:0] r_addr;
    logic [WORD_WIDTH-1:0] r_wdata;

    // Response registers
    logic                  r_resp_valid;
    logic [WORD_WIDTH-1:0] r_resp_rdata;
    logic                  r_resp_err;

    // RAM array (not cleared by reset)
    logic [WORD_WIDTH-1:0] r_mem [DEPTH_WORDS];

    logic                  w_accept;
    logic                  w_consume;
    logic                  w_commit;
    logic                  w_err;
    logic [IDX_W-1:0]      w_idx;
    logic [WORD_WIDTH-1:0] w_old_word;
    logic [WORD_WIDTH-1:0] w_load_data;
    logic [WORD_WIDTH-1:0] w_store_word;

    // r_req_ready is only ever high in IDLE, so this is the IDLE accept.
    assign w_accept  = bus.req_valid & r_req_ready;
    assign w_consume = r_resp_valid & bus.resp_ready;

    // The request is always registered first and committed from the
    // registers: BUSY is visited for WAIT_CYCLES+1 cycles, counting the
    // counter down to zero, which gives a response WAIT_CYCLES+1 edges after
    // the accept edge (one edge for a zero-wait build).
    assign w_commit = (r_state == S_BUSY) && (r_cnt == '0);

    assign w_err = (r_addr >= ADDR_LIMIT) |
                   (~r_byte & (r_addr[1:0] != 2'b00));

    assign w_idx      = r_addr[IDX_W+1:2];
    assign w_old_word = r_mem[w_idx];

    byte_lane_unit u_byte_lane_unit (
        .i_old_word   (w_old_word),
        .i_lane       (r_addr[1:0]),
        .i_wdata      (r_wdata),
        .i_byte       (r_byte),
        .o_load_data  (w_load_data),
        .o_store_word (w_store_word)
    );

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_next = S_BUSY;
                    w_cnt_next   = CNT_LOAD;
                end
            end
            S_BUSY: begin
                if (r_cnt == '0) begin
                    w_state_next = S_RESP;
                end else begin
                    w_cnt_next = r_cnt - CNT_W'(1);
                end
            end
            S_RESP: begin
                if (w_consume) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
                w_cnt_next   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_req_ready  <= 1'b0;
            r_write      <= 1'b0;
            r_byte       <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_resp_valid <= 1'b0;
            r_resp_rdata <= '0;
            r_resp_err   <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_cnt       <= w_cnt_next;
            // Ready is registered from the next state so it rises in the
            // first cycle after reset and one edge after a response is taken.
            r_req_ready <= (w_state_next == S_IDLE);

            if (w_accept) begin
                r_write <= bus.req_write;
                r_byte  <= bus.req_byte;
                r_addr  <= bus.req_addr;
                r_wdata <= bus.req_wdata;
            end

            if (w_commit) begin
                r_resp_valid <= 1'b1;
                r_resp_rdata <= (w_err | r_write) ? '0 : w_load_data;
                r_resp_err   <= w_err;
            end else if (w_consume) begin
                r_resp_valid <= 1'b0;
                r_resp_rdata <= '0;
                r_resp_err   <= 1'b0;
            end
        end
    end

    // Store commit. During reset r_state is IDLE, so a store still in BUSY
    // can never reach this write.
    always_ff @(posedge clk) begin
        if (w_commit && r_write && !w_err) begin
            r_mem[w_idx] <= w_store_word;
        end
    end

    assign bus.req_ready  = r_req_ready;
    assign bus.resp_valid = r_resp_valid;
    assign bus.resp_rdata = r_resp_rdata;
    assign bus.resp_err   = r_resp_err;
    assign o_state        = r_state;

endmodule

// File: tb/tb_data_memory_responder.sv
// -----------------------------------------------------------------------------
// tb_data_memory_responder
// Bench for data_memory_responder: one instance with WAIT_CYCLES=2 (main
// checks, directed table, corner sequences, random traffic against a byte
// model) and one with WAIT_CYCLES=0 (latency and basic data path).
// -----------------------------------------------------------------------------
module tb_data_memory_responder;
    import data_mem_pkg::*;

    localparam int DEPTH = 64;
    localparam int NBYTES = DEPTH * 4;
    localparam int TMO = 40;

    logic       clk;
    logic       reset;
    logic [1:0] state_a;
    logic [1:0] state_b;

    data_memory_responder_if bus_a();
    data_memory_responder_if bus_b();

    data_memory_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(2)) u_dut_w2 (
        .clk     (clk),
        .reset   (reset),
        .bus     (bus_a),
        .o_state (state_a)
    );

    data_memory_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0)) u_dut_w0 (
        .clk     (clk),
        .reset   (reset),
        .bus     (bus_b),
        .o_state (state_b)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard state ----------------
    int          total;
    int          bad;
    logic [32:0] exp_q[$];           // {err, rdata}
    logic [7:0]  model_mem [NBYTES];

    typedef struct {
        logic        w;
        logic        b;
        logic [31:0] a;
        logic [31:0] d;
        logic [31:0] rd;
        logic        er;
    } vec_t;

    vec_t vecs[17];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", name, act, exp);
        end
    endtask

    // Reference: byte-addressed memory, error rules from address arithmetic.
    function automatic void model_apply(input logic w, input logic b,
                                        input logic [31:0] a, input logic [31:0] d,
                                        output logic [31:0] rd, output logic er);
        int base;
        er = (a >= NBYTES) || (!b && (a % 4 != 0));
        rd = 32'h0;
        if (!er) begin
            base = int'(a);
            if (w) begin
                if (b) begin
                    model_mem[base] = d[7:0];
                end else begin
                    for (int k = 0; k < 4; k++) model_mem[base + k] = d[8*k +: 8];
                end
            end else if (b) begin
                rd = {24'h0, model_mem[base]};
            end else begin
                for (int k = 0; k < 4; k++) rd[8*k +: 8] = model_mem[base + k];
            end
        end
    endfunction

    // ---------------- driver tasks ----------------
    task automatic drive_req(input int which, input logic v, input logic w, input logic b,
                             input logic [31:0] a, input logic [31:0] d);
        if (which == 0) begin
            bus_a.req_valid = v; bus_a.req_write = w; bus_a.req_byte = b;
            bus_a.req_addr = a;  bus_a.req_wdata = d;
        end else begin
            bus_b.req_valid = v; bus_b.req_write = w; bus_b.req_byte = b;
            bus_b.req_addr = a;  bus_b.req_wdata = d;
        end
    endtask

    task automatic set_resp_ready(input int which, input logic v);
        if (which == 0) bus_a.resp_ready = v;
        else            bus_b.resp_ready = v;
    endtask

    function automatic logic sel_req_ready(input int which);
        return (which == 0) ? bus_a.req_ready : bus_b.req_ready;
    endfunction

    function automatic logic sel_resp_valid(input int which);
        return (which == 0) ? bus_a.resp_valid : bus_b.resp_valid;
    endfunction

    // One full transaction; lat = edges from accept until resp_valid seen.
    task automatic do_req(input int which, input logic w, input logic b,
                          input logic [31:0] a, input logic [31:0] d,
                          output logic [31:0] rd, output logic er, output int lat);
        int n;
        rd = 32'h0; er = 1'b0; lat = -1; n = 0;
        while (!sel_req_ready(which) && n < TMO) begin
            @(posedge clk); #1; n++;
        end
        if (!sel_req_ready(which)) begin
            check("req_ready_timeout", 32'h0, 32'h1);
            return;
        end
        drive_req(which, 1'b1, w, b, a, d);
        @(posedge clk); #1;
        drive_req(which, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        lat = 0;
        while (!sel_resp_valid(which) && lat < TMO) begin
            @(posedge clk); #1; lat++;
        end
        if (!sel_resp_valid(which)) begin
            check("resp_valid_timeout", 32'h0, 32'h1);
            return;
        end
        rd = (which == 0) ? bus_a.resp_rdata : bus_b.resp_rdata;
        er = (which == 0) ? bus_a.resp_err : bus_b.resp_err;
        set_resp_ready(which, 1'b1);
        @(posedge clk); #1;
        set_resp_ready(which, 1'b0);
        check("resp_cleared", {31'h0, sel_resp_valid(which)}, 32'h0);
    endtask

    // Transaction on the WAIT_CYCLES=2 instance, checked through the model.
    task automatic run_a(input logic w, input logic b, input logic [31:0] a,
                         input logic [31:0] d, input string name);
        logic [31:0] m_rd, rd;
        logic        m_er, er;
        logic [32:0] exp;
        int          lat;
        model_apply(w, b, a, d, m_rd, m_er);
        exp_q.push_back({m_er, m_rd});
        do_req(0, w, b, a, d, rd, er, lat);
        exp = exp_q.pop_front();
        check({name, "_rdata"}, rd, exp[31:0]);
        check({name, "_err"}, {31'h0, er}, {31'h0, exp[32]});
        check({name, "_lat"}, 32'(lat), 32'd3);
    endtask

    // ---------------- main sequence ----------------
    initial begin : main
        logic [31:0] rd;
        logic        er;
        int          lat;
        int          n;
        logic        seen;
        logic [31:0] ra, rdat;
        logic        rw, rb;

        total = 0;
        bad   = 0;
        reset = 1'b0;
        drive_req(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        drive_req(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        set_resp_ready(0, 1'b0);
        set_resp_ready(1, 1'b0);

        repeat (3) @(posedge clk);
        #1;
        check("rst_req_ready", {31'h0, bus_a.req_ready}, 32'h0);
        check("rst_resp_valid", {31'h0, bus_a.resp_valid}, 32'h0);
        check("rst_resp_rdata", bus_a.resp_rdata, 32'h0);
        check("rst_resp_err", {31'h0, bus_a.resp_err}, 32'h0);
        check("rst_state", {30'h0, state_a}, 32'h0);
        check("rst_req_ready_w0", {31'h0, bus_b.req_ready}, 32'h0);

        @(negedge clk) reset = 1'b1;
        @(posedge clk); #1;
        check("post_rst_req_ready", {31'h0, bus_a.req_ready}, 32'h1);
        check("post_rst_req_ready_w0", {31'h0, bus_b.req_ready}, 32'h1);

        // Known contents everywhere: zero all words.
        for (int i = 0; i < DEPTH; i++) run_a(1'b1, 1'b0, 32'(i * 4), 32'h0, "init");

        // Directed table (expected values hand-derived).
        vecs[0]  = '{1'b1, 1'b0, 32'd32,         32'h0000000F, 32'h00000000, 1'b0};
        vecs[1]  = '{1'b0, 1'b0, 32'd32,         32'h0,        32'h0000000F, 1'b0};
        vecs[2]  = '{1'b1, 1'b0, 32'd8,          32'h11223344, 32'h00000000, 1'b0};
        vecs[3]  = '{1'b1, 1'b1, 32'd10,         32'h555555AA, 32'h00000000, 1'b0};
        vecs[4]  = '{1'b0, 1'b0, 32'd8,          32'h0,        32'h11AA3344, 1'b0};
        vecs[5]  = '{1'b0, 1'b1, 32'd11,         32'h0,        32'h00000011, 1'b0};
        vecs[6]  = '{1'b0, 1'b1, 32'd8,          32'h0,        32'h00000044, 1'b0};
        vecs[7]  = '{1'b0, 1'b0, 32'd6,          32'h0,        32'h00000000, 1'b1};
        vecs[8]  = '{1'b1, 1'b0, 32'd256,        32'h12345678, 32'h00000000, 1'b1};
        vecs[9]  = '{1'b0, 1'b0, 32'd0,          32'h0,        32'h00000000, 1'b0};
        vecs[10] = '{1'b1, 1'b1, 32'd255,        32'h0000005A, 32'h00000000, 1'b0};
        vecs[11] = '{1'b0, 1'b0, 32'd252,        32'h0,        32'h5A000000, 1'b0};
        vecs[12] = '{1'b0, 1'b1, 32'd256,        32'h0,        32'h00000000, 1'b1};
        vecs[13] = '{1'b1, 1'b0, 32'd2,          32'hCAFECAFE, 32'h00000000, 1'b1};
        vecs[14] = '{1'b0, 1'b0, 32'd0,          32'h0,        32'h00000000, 1'b0};
        vecs[15] = '{1'b0, 1'b0, 32'hFFFFFFFC,   32'h0,        32'h00000000, 1'b1};
        vecs[16] = '{1'b0, 1'b1, 32'd2,          32'h0,        32'h00000000, 1'b0};

        for (int i = 0; i < 17; i++) begin
            logic [31:0] m_rd;
            logic        m_er;
            model_apply(vecs[i].w, vecs[i].b, vecs[i].a, vecs[i].d, m_rd, m_er);
            do_req(0, vecs[i].w, vecs[i].b, vecs[i].a, vecs[i].d, rd, er, lat);
            check($sformatf("vec%0d_rdata", i), rd, vecs[i].rd);
            check($sformatf("vec%0d_err", i), {31'h0, er}, {31'h0, vecs[i].er});
            check($sformatf("vec%0d_lat", i), 32'(lat), 32'd3);
        end

        // Backpressure: response held 5 cycles, a stray request is ignored.
        drive_req(0, 1'b1, 1'b0, 1'b0, 32'd32, 32'h0);
        @(posedge clk); #1;
        drive_req(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        n = 0;
        while (!bus_a.resp_valid && n < TMO) begin @(posedge clk); #1; n++; end
        check("bp_resp_seen", {31'h0, bus_a.resp_valid}, 32'h1);
        for (int c = 0; c < 5; c++) begin
            check("bp_valid_hold", {31'h0, bus_a.resp_valid}, 32'h1);
            check("bp_rdata_hold", bus_a.resp_rdata, 32'h0000000F);
            check("bp_req_ready_low", {31'h0, bus_a.req_ready}, 32'h0);
            if (c == 1) drive_req(0, 1'b1, 1'b1, 1'b0, 32'd32, 32'h00000BAD);
            @(posedge clk); #1;
            drive_req(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        end
        set_resp_ready(0, 1'b1);
        @(posedge clk); #1;
        set_resp_ready(0, 1'b0);
        seen = 1'b0;
        for (int c = 0; c < 6; c++) begin
            seen = seen | bus_a.resp_valid;
            @(posedge clk); #1;
        end
        check("bp_no_second_resp", {31'h0, seen}, 32'h0);
        run_a(1'b0, 1'b0, 32'd32, 32'h0, "bp_readback");

        // Reset while BUSY: the store is dropped.
        drive_req(0, 1'b1, 1'b1, 1'b0, 32'd4, 32'hDEADBEEF);
        @(posedge clk); #1;
        drive_req(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        check("abort_in_busy", {30'h0, state_a}, 32'h1);
        @(negedge clk) reset = 1'b0;
        #1;
        check("abort_valid", {31'h0, bus_a.resp_valid}, 32'h0);
        check("abort_req_ready", {31'h0, bus_a.req_ready}, 32'h0);
        check("abort_state", {30'h0, state_a}, 32'h0);
        @(posedge clk);
        @(negedge clk) reset = 1'b1;
        @(posedge clk); #1;
        check("abort_ready_back", {31'h0, bus_a.req_ready}, 32'h1);
        run_a(1'b0, 1'b0, 32'd4, 32'h0, "abort_readback");

        // Reset while RESP: the store already committed is kept.
        drive_req(0, 1'b1, 1'b1, 1'b0, 32'd12, 32'hCAFEF00D);
        @(posedge clk); #1;
        drive_req(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        n = 0;
        while (!bus_a.resp_valid && n < TMO) begin @(posedge clk); #1; n++; end
        check("resp_reset_seen", {31'h0, bus_a.resp_valid}, 32'h1);
        model_apply(1'b1, 1'b0, 32'd12, 32'hCAFEF00D, rd, er);
        @(negedge clk) reset = 1'b0;
        #1;
        check("resp_reset_valid", {31'h0, bus_a.resp_valid}, 32'h0);
        @(negedge clk) reset = 1'b1;
        @(posedge clk); #1;
        run_a(1'b0, 1'b0, 32'd12, 32'h0, "resp_reset_readback");

        // Zero-wait instance: one-edge latency and data path.
        do_req(1, 1'b1, 1'b0, 32'd16, 32'h0BADF00D, rd, er, lat);
        check("w0_str_lat", 32'(lat), 32'd1);
        check("w0_str_err", {31'h0, er}, 32'h0);
        do_req(1, 1'b0, 1'b0, 32'd16, 32'h0, rd, er, lat);
        check("w0_ldr_lat", 32'(lat), 32'd1);
        check("w0_ldr_rdata", rd, 32'h0BADF00D);
        do_req(1, 1'b0, 1'b1, 32'd17, 32'h0, rd, er, lat);
        check("w0_ldrb_rdata", rd, 32'h000000F0);
        do_req(1, 1'b0, 1'b0, 32'd18, 32'h0, rd, er, lat);
        check("w0_misaligned_err", {31'h0, er}, 32'h1);
        check("w0_misaligned_rdata", rd, 32'h0);

        // Random traffic against the model.
        for (int i = 0; i < 150; i++) begin
            rw = 1'($urandom_range(0, 1));
            rb = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 9) == 0) ra = 32'($urandom_range(NBYTES, NBYTES + 40));
            else                           ra = 32'($urandom_range(0, NBYTES - 1));
            if (!rb && $urandom_range(0, 3) != 0) ra = ra & 32'hFFFFFFFC;
            rdat = $urandom;
            run_a(rw, rb, ra, rdat, "rand");
        end

        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
